// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle EXEC/MEM/WB sequencer for RV32I/RV64I.
// Ports: clk, rst (async, active high); instr_valid/instr_ready handshake
//   with decoded fields opcode, funct3, rd_addr, rs1_val, rs2_val, imm, pc_in;
//   alu_result/alu_en to the ALU; mem_req/mem_we/mem_addr/mem_wdata/mem_be,
//   mem_rdata/mem_ack to data memory; rf_we/rf_waddr/rf_wdata to the register
//   file; j_valid/j_target to the PC; instr_done, illegal, mem_err pulses.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned accesses
//   and misaligned jump/branch targets (PC_STEP = 4) with mem_err.
module exec_sequencer #(
  parameter int XLEN        = 32,
  parameter int PC_STEP     = 1,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd_addr,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   alu_result,
  output logic              alu_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              j_valid,
  output logic [XLEN-1:0]   j_target,
  output logic              instr_done,
  output logic              illegal,
  output logic              mem_err
);

  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [1:0]      state;
  logic [6:0]      op_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rs1_q, rs2_q, imm_q, pc_q;
  logic [XLEN-1:0] alu_q, ld_q;
  logic            err_q;
  logic [31:0]     wcnt;

  logic is_op, is_lui, is_auipc, is_br, is_jal, is_jalr, is_ld, is_st;
  logic bad, taken, jump, tgt_bad, acc_bad, writes, wb;
  logic [XLEN-1:0] addr, target, link, lsh, ld_val, wb_data;
  logic [LB-1:0]   lane;
  logic [NB-1:0]   be_base;

  assign is_op    = (op_q == OP_OP) || (op_q == OP_IMM);
  assign is_lui   = (op_q == OP_LUI);
  assign is_auipc = (op_q == OP_AUIPC);
  assign is_br    = (op_q == OP_BR);
  assign is_jal   = (op_q == OP_JAL);
  assign is_jalr  = (op_q == OP_JALR);
  assign is_ld    = (op_q == OP_LOAD);
  assign is_st    = (op_q == OP_STORE);

  // Reserved funct3 encodings; 64-bit forms are reserved on RV32.
  always_comb begin
    bad = !(is_op || is_lui || is_auipc || is_br ||
            is_jal || is_jalr || is_ld || is_st);
    if (is_ld && (f3_q == 3'b111 ||
        (XLEN == 32 && (f3_q == 3'b011 || f3_q == 3'b110))))
      bad = 1'b1;
    if (is_st && (f3_q[2] || (XLEN == 32 && f3_q == 3'b011)))
      bad = 1'b1;
    if (is_br && (f3_q == 3'b010 || f3_q == 3'b011))
      bad = 1'b1;
  end

  assign addr = rs1_q + imm_q;
  assign lane = addr[LB-1:0];
  assign link = pc_q + XLEN'(PC_STEP);

  always_comb begin
    case (f3_q)
      3'b000:  taken = (rs1_q == rs2_q);
      3'b001:  taken = (rs1_q != rs2_q);
      3'b100:  taken = ($signed(rs1_q) < $signed(rs2_q));
      3'b101:  taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  taken = (rs1_q < rs2_q);
      3'b111:  taken = (rs1_q >= rs2_q);
      default: taken = 1'b0;
    endcase
  end

  assign jump   = !bad && (is_jal || is_jalr || (is_br && taken));
  assign target = is_jalr ? (addr & ~XLEN'(1)) : (pc_q + imm_q);

`ifdef MISALIGN_TRAP_EN
  assign tgt_bad = (PC_STEP == 4) && target[1];
  always_comb begin
    case (f3_q[1:0])
      2'd1:    acc_bad = addr[0];
      2'd2:    acc_bad = (addr[1:0] != 2'b00);
      2'd3:    acc_bad = (addr[2:0] != 3'b000);
      default: acc_bad = 1'b0;
    endcase
  end
`else
  assign tgt_bad = 1'b0;
  assign acc_bad = 1'b0;
`endif

  // Shifting the base mask by the lane drops lanes past the word end.
  always_comb begin
    case (f3_q[1:0])
      2'd0:    be_base = NB'(1);
      2'd1:    be_base = NB'(3);
      2'd2:    be_base = NB'(15);
      default: be_base = '1;
    endcase
  end

  assign lsh = mem_rdata >> {lane, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ld_val = XLEN'($signed(lsh[7:0]));
      3'b001:  ld_val = XLEN'($signed(lsh[15:0]));
      3'b010:  ld_val = XLEN'($signed(lsh[31:0]));
      3'b100:  ld_val = XLEN'(lsh[7:0]);
      3'b101:  ld_val = XLEN'(lsh[15:0]);
      3'b110:  ld_val = XLEN'(lsh[31:0]);
      default: ld_val = lsh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= '0;
      f3_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      pc_q  <= '0;
      alu_q <= '0;
      ld_q  <= '0;
      err_q <= 1'b0;
      wcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (instr_valid) begin
          op_q  <= opcode;
          f3_q  <= funct3;
          rd_q  <= rd_addr;
          rs1_q <= rs1_val;
          rs2_q <= rs2_val;
          imm_q <= imm;
          pc_q  <= pc_in;
          err_q <= 1'b0;
          wcnt  <= '0;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_op) alu_q <= alu_result;
          if ((is_ld || is_st) && !bad && !acc_bad) begin
            state <= S_MEM;
          end else begin
            err_q <= (is_ld || is_st) && !bad && acc_bad;
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            ld_q  <= ld_val;
            state <= S_WB;
          end else if (MEM_TIMEOUT > 0 &&
                       wcnt == 32'(MEM_TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= S_WB;
          end else begin
            wcnt <= wcnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign writes = is_op || is_lui || is_auipc ||
                  is_jal || is_jalr || is_ld;

  always_comb begin
    wb_data = alu_q;
    if (is_lui)             wb_data = imm_q;
    if (is_auipc)           wb_data = pc_q + imm_q;
    if (is_jal || is_jalr)  wb_data = link;
    if (is_ld)              wb_data = ld_q;
  end

  assign wb          = (state == S_WB);
  assign instr_ready = (state == S_IDLE);
  assign alu_en      = (state == S_EXEC) && is_op;
  assign mem_req     = (state == S_MEM);
  assign mem_we      = mem_req && is_st;
  assign mem_addr    = mem_req ? addr : '0;
  assign mem_be      = mem_we ? (be_base << lane) : '0;
  assign mem_wdata   = mem_we ? (rs2_q << {lane, 3'b000}) : '0;
  assign instr_done  = wb;
  assign illegal     = wb && bad;
  assign mem_err     = wb && (err_q || (jump && tgt_bad));
  assign j_valid     = wb && jump && !tgt_bad;
  assign j_target    = j_valid ? target : '0;
  assign rf_we       = wb && writes && !bad && !err_q && (rd_q != 5'd0);
  assign rf_waddr    = rf_we ? rd_q : '0;
  assign rf_wdata    = rf_we ? wb_data : '0;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed and random checks of exec_sequencer
// against a spec-level reference model (XLEN 32, PC_STEP 4, timeout 4).
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rs1_val = '0, rs2_val = '0, imm = '0, pc_in = '0;
  logic [31:0] alu_result = '0;
  logic        alu_en, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        j_valid;
  logic [31:0] j_target;
  logic        instr_done, illegal, mem_err;

  int n_cmp = 0;
  int n_err = 0;

  exec_sequencer #(.XLEN(32), .PC_STEP(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct3(funct3), .rd_addr(rd_addr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc_in(pc_in),
    .alu_result(alu_result), .alu_en(alu_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .j_valid(j_valid), .j_target(j_target),
    .instr_done(instr_done), .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  localparam longint unsigned W = 64'h1_0000_0000;

  typedef struct {
    bit          we;
    logic [31:0] wd;
    bit          jv;
    logic [31:0] jt;
    bit          ill;
    bit          err;
    bit          mem;
    bit          st;
    logic [31:0] ma;
    logic [3:0]  be;
    logic [31:0] md;
    int          lat;
    bit          alu;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sval(input logic [31:0] v);
    return (v >= 32'h8000_0000) ? longint'(v) - longint'(W) : longint'(v);
  endfunction

  // waits >= 4 means memory never acknowledges.
  function automatic exp_t model(
      input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] im,
      input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rdata,
      input int waits);
    exp_t e;
    longint unsigned a, v, n, off, span;
    bit t;
    e = '{default: 0};
    e.lat = 2;
    a = (longint'(rs1) + longint'(im)) % W;
    case (op)
      7'h33, 7'h13: begin e.alu = 1; e.we = rd != 0; e.wd = alu; end
      7'h37: begin e.we = rd != 0; e.wd = im; end
      7'h17: begin e.we = rd != 0; e.wd = 32'((longint'(pc) + im) % W); end
      7'h63: begin
        t = 0;
        case (f3)
          0: t = rs1 == rs2;
          1: t = rs1 != rs2;
          4: t = sval(rs1) < sval(rs2);
          5: t = sval(rs1) >= sval(rs2);
          6: t = longint'(rs1) < longint'(rs2);
          7: t = longint'(rs1) >= longint'(rs2);
          default: e.ill = 1;
        endcase
        if (t) begin e.jv = 1; e.jt = 32'((longint'(pc) + im) % W); end
      end
      7'h6F, 7'h67: begin
        e.jv = 1;
        e.jt = (op == 7'h6F) ? 32'((longint'(pc) + im) % W)
                             : 32'(a - (a % 2));
        e.we = rd != 0;
        e.wd = 32'((longint'(pc) + 4) % W);
      end
      7'h03, 7'h23: begin
        e.st = (op == 7'h23);
        if ((!e.st && (f3 == 3 || f3 == 6 || f3 == 7)) ||
            (e.st && f3 >= 3)) begin
          e.ill = 1; e.st = 0;
        end else begin
          e.mem = 1;
          e.ma = 32'(a);
          n = 1 << f3[1:0];
          off = a % 4;
          for (int i = 0; i < 4; i++)
            e.be[i] = (i >= off) && (i < off + n);
          e.md = 32'((longint'(rs2) << (8 * off)) % W);
          if (waits >= 4) begin
            e.err = 1; e.lat = 6;
          end else begin
            e.lat = 3 + waits;
            if (!e.st) begin
              span = longint'(1) << (8 * n);
              v = (longint'(rdata) >> (8 * off)) % span;
              if (!f3[2] && v >= span / 2) v = (v + W - span) % W;
              e.we = rd != 0;
              e.wd = 32'(v);
            end
          end
        end
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic run(input string tag, input logic [6:0] op,
      input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] rs1,
      input logic [31:0] rs2, input logic [31:0] im, input logic [31:0] pc,
      input logic [31:0] alu, input logic [31:0] rdata, input int waits);
    exp_t e;
    int done_cyc, nreq, nwe, njv, nill, nerr, nalu;
    logic [31:0] wd, jt, ma, md;
    logic [4:0] wa;
    logic [3:0] be;
    logic mw;
    bit stable;
    e = model(op, f3, rd, rs1, rs2, im, pc, alu, rdata, waits);
    {done_cyc, nreq, nwe, njv, nill, nerr, nalu} = '0;
    {wd, jt, ma, md, wa, be, mw} = '0;
    stable = 1;
    chk({tag, ".ready"}, instr_ready, 1);
    opcode = op; funct3 = f3; rd_addr = rd; rs1_val = rs1;
    rs2_val = rs2; imm = im; pc_in = pc; alu_result = alu;
    mem_rdata = rdata; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (mem_req) begin
        nreq++;
        if (nreq == 1) begin
          ma = mem_addr; md = mem_wdata; be = mem_be; mw = mem_we;
        end else if (ma !== mem_addr || md !== mem_wdata ||
                     be !== mem_be || mw !== mem_we) begin
          stable = 0;
        end
      end
      mem_ack = mem_req && waits < 4 && nreq == waits + 1;
      if (alu_en) nalu++;
      if (rf_we) begin nwe++; wd = rf_wdata; wa = rf_waddr; end
      if (j_valid) begin njv++; jt = j_target; end
      if (illegal) nill++;
      if (mem_err) nerr++;
      if (instr_done && done_cyc == 0) done_cyc = cyc;
      @(posedge clk); #1;
      if (done_cyc != 0) break;
    end
    mem_ack = 1'b0;
    chk({tag, ".latency"}, done_cyc, e.lat);
    chk({tag, ".rf_we"}, nwe, e.we);
    if (e.we) begin
      chk({tag, ".rf_wdata"}, wd, e.wd);
      chk({tag, ".rf_waddr"}, wa, rd);
    end
    chk({tag, ".j_valid"}, njv, e.jv);
    if (e.jv) chk({tag, ".j_target"}, jt, e.jt);
    chk({tag, ".illegal"}, nill, e.ill);
    chk({tag, ".mem_err"}, nerr, e.err);
    chk({tag, ".alu_en"}, nalu, e.alu);
    chk({tag, ".mem_cycles"}, nreq,
        e.mem ? (e.err ? 4 : waits + 1) : 0);
    if (e.mem && nreq > 0) begin
      chk({tag, ".mem_addr"}, ma, e.ma);
      chk({tag, ".mem_we"}, mw, e.st);
      chk({tag, ".mem_stable"}, stable, 1);
      if (e.st) begin
        chk({tag, ".mem_be"}, be, e.be);
        chk({tag, ".mem_wdata"}, md, e.md);
      end
    end
  endtask

  initial begin
    int k, w;
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] r1, r2;
    logic [6:0] bad_ops [4];
    bad_ops = '{7'h7F, 7'h0F, 7'h73, 7'h00};

    repeat (2) @(posedge clk);
    #1;
    chk("reset.ready", instr_ready, 1);
    chk("reset.outs", {alu_en, mem_req, mem_we, rf_we, j_valid,
                       instr_done, illegal, mem_err}, 0);
    chk("reset.buses", {mem_addr, mem_wdata, mem_be, rf_wdata, j_target}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    opcode = 7'h03; funct3 = 3'b010; rd_addr = 5'd3;
    rs1_val = 32'h100; imm = 32'h0; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstmem.req_before", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmem.req_now", mem_req, 0);
    chk("rstmem.ready", instr_ready, 1);
    chk("rstmem.addr", mem_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    k = 0;
    repeat (5) begin
      if (rf_we || j_valid || instr_done) k++;
      @(posedge clk); #1;
    end
    chk("rstmem.no_retire", k, 0);

    run("add", 7'h33, 0, 5, 32'h3, 32'h4, 0, 0, 32'h15, 0, 0);
    run("blt", 7'h63, 3'b100, 0, 32'hFFFF_FFFF, 1, 32'h10, 32'h40, 0, 0, 0);
    run("bltu", 7'h63, 3'b110, 0, 32'hFFFF_FFFF, 1, 32'h10, 32'h40, 0, 0, 0);
    run("lb101", 7'h03, 3'b000, 7, 32'h100, 0, 1, 0, 0, 32'h80FF7F01, 3);
    run("lbu101", 7'h03, 3'b100, 7, 32'h100, 0, 1, 0, 0, 32'h80FF7F01, 3);
    run("lb102", 7'h03, 3'b000, 7, 32'h100, 0, 2, 0, 0, 32'h80FF7F01, 3);
    run("lbu102", 7'h03, 3'b100, 7, 32'h100, 0, 2, 0, 0, 32'h80FF7F01, 3);
    run("lh", 7'h03, 3'b001, 9, 32'h200, 0, 2, 0, 0, 32'h80FF7F01, 0);
    run("sh", 7'h23, 3'b001, 0, 32'h200, 32'hABCD, 2, 0, 0, 0, 2);
    run("jalr", 7'h67, 0, 1, 32'h101, 0, 2, 32'h20, 0, 0, 0);
    run("jalr_x0", 7'h67, 0, 0, 32'h101, 0, 2, 32'h20, 0, 0, 0);
    run("jal_wrap", 7'h6F, 0, 2, 0, 0, 32'h10, 32'hFFFF_FFF8, 0, 0, 0);
    run("illegal", 7'h7F, 0, 4, 1, 2, 3, 4, 5, 0, 0);
    run("ld_rv32", 7'h03, 3'b011, 4, 32'h100, 0, 0, 0, 0, 0, 0);
    run("timeout", 7'h23, 3'b010, 0, 32'h300, 32'h1234, 0, 0, 0, 0, 4);

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      w = $urandom_range(0, 4);
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      case (k)
        0: op = 7'h33;
        1: op = 7'h13;
        2: op = 7'h37;
        3: op = 7'h17;
        4: op = 7'h63;
        5: op = 7'h6F;
        6: op = 7'h67;
        7: op = 7'h03;
        8: op = 7'h23;
        default: op = bad_ops[$urandom_range(0, 3)];
      endcase
      run($sformatf("rnd%0d", i), op, f3, 5'($urandom_range(0, 31)),
          r1, r2, $urandom, $urandom, $urandom, $urandom, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
